// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: column-scan controller for a 4x4 active-low matrix keypad.
// Debounces presses and releases and strobes key_valid_o once per accepted press.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] row_i,
    output logic [3:0] col_o,
    output logic [3:0] key_code_o,
    output logic       key_valid_o,
    output logic       key_held_o
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DBC_W = $clog2(DEBOUNCE + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DBC_W-1:0] DBC_DONE = DBC_W'(DEBOUNCE);
    localparam logic [DBC_W-1:0] DBC_ONE  = DBC_W'(1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD,
        ST_RELEASE
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         rowMeta_q, rowSync_q;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DBC_W-1:0]   dbc_q, dbc_d, dbcInc;
    logic [1:0]         colIdx_q, colIdx_d;
    logic [1:0]         rowIdx_q, rowIdx_d;
    logic [3:0]         pattern_q, pattern_d;
    logic [3:0]         keyCode_q, keyCode_d;
    logic               keyValid_q, keyValid_d;
    logic               tick, oneLow;
    logic [1:0]         rowHit;

    always_comb begin
        tick   = (div_q == DIV_LAST);
        dbcInc = (dbc_q == DBC_DONE) ? dbc_q : dbc_q + 1'b1;
        oneLow = 1'b1;
        rowHit = 2'd0;
        unique case (rowSync_q)
            4'b1110: rowHit = 2'd0;
            4'b1101: rowHit = 2'd1;
            4'b1011: rowHit = 2'd2;
            4'b0111: rowHit = 2'd3;
            default: oneLow = 1'b0;
        endcase
    end

    // Multi-key patterns (ghosting) count as no key, so only a single low row can start a press.
    always_comb begin
        state_d    = state_q;
        dbc_d      = dbc_q;
        colIdx_d   = colIdx_q;
        rowIdx_d   = rowIdx_q;
        pattern_d  = pattern_q;
        keyCode_d  = keyCode_q;
        keyValid_d = 1'b0;
        if (tick) begin
            unique case (state_q)
                ST_SCAN: begin
                    if (oneLow) begin
                        rowIdx_d  = rowHit;
                        pattern_d = rowSync_q;
                        dbc_d     = DBC_ONE;
                        if (DEBOUNCE == 1) begin
                            keyCode_d  = {rowHit, colIdx_q};
                            keyValid_d = 1'b1;
                            state_d    = ST_HELD;
                        end else begin
                            state_d = ST_DEBOUNCE;
                        end
                    end else begin
                        colIdx_d = colIdx_q + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (rowSync_q == pattern_q) begin
                        dbc_d = dbcInc;
                        if (dbcInc == DBC_DONE) begin
                            keyCode_d  = {rowIdx_q, colIdx_q};
                            keyValid_d = 1'b1;
                            state_d    = ST_HELD;
                        end
                    end else begin
                        state_d  = ST_SCAN;
                        colIdx_d = colIdx_q + 2'd1;
                    end
                end
                ST_HELD: begin
                    if (rowSync_q == 4'b1111) begin
                        dbc_d = DBC_ONE;
                        if (DEBOUNCE == 1) begin
                            state_d  = ST_SCAN;
                            colIdx_d = colIdx_q + 2'd1;
                        end else begin
                            state_d = ST_RELEASE;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (rowSync_q == 4'b1111) begin
                        dbc_d = dbcInc;
                        if (dbcInc == DBC_DONE) begin
                            state_d  = ST_SCAN;
                            colIdx_d = colIdx_q + 2'd1;
                        end
                    end else begin
                        state_d = ST_HELD;
                    end
                end
                default: state_d = ST_SCAN;
            endcase
        end
        div_d = (tick || (state_d != state_q)) ? '0 : div_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_SCAN;
            rowMeta_q  <= 4'b1111;
            rowSync_q  <= 4'b1111;
            div_q      <= '0;
            dbc_q      <= '0;
            colIdx_q   <= 2'd0;
            rowIdx_q   <= 2'd0;
            pattern_q  <= 4'b1111;
            keyCode_q  <= 4'd0;
            keyValid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rowMeta_q  <= row_i;
            rowSync_q  <= rowMeta_q;
            div_q      <= div_d;
            dbc_q      <= dbc_d;
            colIdx_q   <= colIdx_d;
            rowIdx_q   <= rowIdx_d;
            pattern_q  <= pattern_d;
            keyCode_q  <= keyCode_d;
            keyValid_q <= keyValid_d;
        end
    end

    assign col_o       = ~(4'b0001 << colIdx_q);
    assign key_code_o  = keyCode_q;
    assign key_valid_o = keyValid_q;
    assign key_held_o  = (state_q == ST_HELD) || (state_q == ST_RELEASE);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Testbench for keypad_scan_ctrl: a keypad model drives the rows from the column
// drive, and a tick-level behavioural model predicts every output each cycle.
module tb_keypad_scan_ctrl;

   localparam int SCAN_DIV = 4;
   localparam int DEBOUNCE = 3;

   logic        clk;
   logic        rst_n;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [3:0]  keyCode;
   logic        keyValid;
   logic        keyHeld;
   logic [15:0] pressMask;

   int checkCount = 0;
   int passCount  = 0;
   int pulses     = 0;
   int pulseBase;
   logic prevValid = 1'b0;

   keypad_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .row_i       (row),
      .col_o       (col),
      .key_code_o  (keyCode),
      .key_valid_o (keyValid),
      .key_held_o  (keyHeld)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Physical keypad: a pressed key pulls its row low only while its column is driven low.
   always_comb begin
      row = 4'b1111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressMask[r*4+c] && !col[c]) row[r] = 1'b0;
   end

   // Reference model: samples arrive every SCAN_DIV edges and see the row pins from two edges earlier.
   logic [3:0] hist1, hist2, mSample, mPat, mCode;
   logic [1:0] mColIdx;
   int         mCycle, mMatch, mIdle, mRow;
   bit         mLocked, mValid;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist1 = 4'hF; hist2 = 4'hF; mPat = 4'hF; mCode = 4'h0;
         mColIdx = 2'd0; mCycle = 0; mMatch = 0; mIdle = 0; mRow = 0;
         mLocked = 0; mValid = 0;
      end else begin
         mValid  = 0;
         mCycle  = mCycle + 1;
         mSample = hist2;
         hist2   = hist1;
         hist1   = row;
         if (mCycle % SCAN_DIV == 0) begin
            if (mLocked) begin
               if (mSample == 4'hF) begin
                  mIdle = mIdle + 1;
                  if (mIdle >= DEBOUNCE) begin
                     mLocked = 0; mIdle = 0; mColIdx = mColIdx + 2'd1;
                  end
               end else begin
                  mIdle = 0;
               end
            end else if (mMatch > 0) begin
               if (mSample == mPat) begin
                  mMatch = mMatch + 1;
               end else begin
                  mMatch = 0; mColIdx = mColIdx + 2'd1;
               end
            end else if ($countones(~mSample) == 1) begin
               mPat = mSample; mMatch = 1;
               for (int r = 0; r < 4; r++) if (!mSample[r]) mRow = r;
            end else begin
               mColIdx = mColIdx + 2'd1;
            end
            if (mMatch >= DEBOUNCE) begin
               mCode = 4'(mRow * 4 + int'(mColIdx));
               mValid = 1; mLocked = 1; mMatch = 0; mIdle = 0;
            end
         end
      end
   end

   function automatic logic [3:0] expCol(input logic [1:0] idx);
      logic [3:0] v;
      v = 4'b1111;
      v[idx] = 1'b0;
      return v;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected)
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
      else
         passCount++;
   endtask

   always @(posedge clk) if (keyValid === 1'b1) pulses++;

   // Every cycle the DUT outputs are held against the model.
   always @(negedge clk) begin
      checkOutput("col", col, expCol(mColIdx));
      checkOutput("keyValid", keyValid, mValid);
      checkOutput("keyHeld", keyHeld, mLocked);
      checkOutput("keyCode", keyCode, mCode);
      checkOutput("validTwice", keyValid & prevValid, 0);
      prevValid = keyValid;
   end

   task automatic applyStimulus(input logic [15:0] mask, input int ticks);
      pressMask = mask;
      repeat (ticks * SCAN_DIV) @(negedge clk);
   endtask

   task automatic waitHeld(input logic level, input string tag);
      int n = 0;
      while (keyHeld !== level && n < 400) begin
         @(negedge clk);
         n++;
      end
      checkOutput(tag, keyHeld, level);
   endtask

   initial begin
      logic [15:0] mask;
      int kind, k1, k2;
      rst_n = 1'b0;
      pressMask = '0;
      repeat (3) @(negedge clk);
      checkOutput("resetCol", col, 4'b1110);
      checkOutput("resetCode", keyCode, 0);
      checkOutput("resetValid", keyValid, 0);
      checkOutput("resetHeld", keyHeld, 0);

      $display("[TB] bounce: key 0 opens before the third sample");
      pulseBase = pulses;
      pressMask = 16'h0001;
      rst_n = 1'b1;
      repeat (7) @(negedge clk);
      pressMask = '0;
      repeat (5) @(negedge clk);
      checkOutput("bounceCol", col, 4'b1101);
      checkOutput("bouncePulses", pulses - pulseBase, 0);
      applyStimulus('0, 4);

      $display("[TB] press row1/col2 and hold 20 ticks");
      pulseBase = pulses;
      pressMask = 16'h0040;
      waitHeld(1'b1, "t1Held");
      checkOutput("t1Code", keyCode, 4'h6);
      applyStimulus(16'h0040, 20);
      checkOutput("t1StillHeld", keyHeld, 1);
      pressMask = '0;
      waitHeld(1'b0, "t1Release");
      checkOutput("t1Pulses", pulses - pulseBase, 1);
      applyStimulus('0, 3);

      $display("[TB] press row0/col3");
      pulseBase = pulses;
      pressMask = 16'h0008;
      waitHeld(1'b1, "t2Held");
      checkOutput("t2Code", keyCode, 4'h3);
      applyStimulus(16'h0008, 6);
      checkOutput("t2ColFrozen", col, 4'b0111);
      pressMask = '0;
      waitHeld(1'b0, "t2Release");
      checkOutput("t2ColRotated", col, 4'b1110);
      checkOutput("t2Pulses", pulses - pulseBase, 1);
      applyStimulus('0, 3);

      $display("[TB] release glitch on row1/col1");
      pulseBase = pulses;
      pressMask = 16'h0020;
      waitHeld(1'b1, "t4Held");
      repeat (9) @(negedge clk);
      pressMask = '0;
      repeat (8) @(negedge clk);
      pressMask = 16'h0020;
      repeat (3) @(negedge clk);
      checkOutput("t4HeldAfterGlitch", keyHeld, 1);
      applyStimulus(16'h0020, 5);
      checkOutput("t4HeldLater", keyHeld, 1);
      pressMask = '0;
      waitHeld(1'b0, "t4Release");
      checkOutput("t4Pulses", pulses - pulseBase, 1);
      checkOutput("t4Code", keyCode, 4'h5);
      applyStimulus('0, 3);

      $display("[TB] two keys in one column");
      pulseBase = pulses;
      applyStimulus(16'h0022, 16);
      checkOutput("t5Pulses", pulses - pulseBase, 0);
      checkOutput("t5Held", keyHeld, 0);
      applyStimulus('0, 3);

      $display("[TB] reset while held");
      pulseBase = pulses;
      pressMask = 16'h0200;
      waitHeld(1'b1, "t6Held");
      checkOutput("t6Code", keyCode, 4'h9);
      repeat (6) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("t6RstCol", col, 4'b1110);
      checkOutput("t6RstValid", keyValid, 0);
      checkOutput("t6RstHeld", keyHeld, 0);
      checkOutput("t6RstCode", keyCode, 0);
      @(negedge clk);
      rst_n = 1'b1;
      pulseBase = pulses;
      waitHeld(1'b1, "t6Reheld");
      checkOutput("t6Recode", keyCode, 4'h9);
      applyStimulus(16'h0200, 4);
      checkOutput("t6Pulses", pulses - pulseBase, 1);
      pressMask = '0;
      waitHeld(1'b0, "t6Release");

      $display("[TB] randomized presses");
      for (int i = 0; i < 25; i++) begin
         kind = $urandom_range(0, 9);
         k1 = $urandom_range(0, 15);
         k2 = (k1 + $urandom_range(1, 15)) % 16;
         mask = '0;
         if (kind != 0) mask[k1] = 1'b1;
         if (kind == 1) mask[k2] = 1'b1;
         applyStimulus(mask, $urandom_range(1, 25));
         applyStimulus('0, $urandom_range(0, 10));
      end
      applyStimulus('0, 6);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
